// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 NOR flash responder (READ/RDSR/RDID) on synchronized pins, with a preload write port into its byte memory
module spi_flash_responder #(
  parameter int          MEM_DEPTH   = 1024,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sclk_i,
  input  logic                         cs_n_i,
  input  logic                         mosi_i,
  output logic                         miso_o,
  output logic                         miso_oe_o,
  input  logic                         load_en_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] load_addr_i,
  input  logic [7:0]                   load_data_i,
  output logic                         busy_o,
  output logic [7:0]                   last_cmd_o,
  output logic                         bad_cmd_o
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int RW = (AW > 8 ? AW : 8) - 1;
  localparam logic [AW-1:0] ONE = 1;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STAT, ID, IGNORE} state_t;
  state_t state, state_n;
  logic [2:0] sclk_s, cs_s;
  logic [1:0] mosi_s, id_idx, id_idx_n;
  logic [4:0] cnt, cnt_n;
  logic [RW-1:0] rx, rx_n;
  logic [AW-1:0] addr, addr_n, fetch_addr;
  logic [7:0] tx, tx_n, fetch_data, next_byte, opcode, last_cmd_n;
  logic miso_q, miso_n, bad_n, rise, fall, cs_hi, cs_fall, bit_in;
  logic [7:0] mem [MEM_DEPTH];
  assign rise = sclk_s[1] & ~sclk_s[2];
  assign fall = ~sclk_s[1] & sclk_s[2];
  assign cs_hi = cs_s[1];
  assign cs_fall = cs_s[2] & ~cs_s[1];
  assign bit_in = mosi_s[1];
  assign opcode = {rx[6:0], bit_in};
  assign fetch_addr = state == ADDR ? {rx[AW-2:0], bit_in} : addr + ONE;
  assign fetch_data = (load_en_i && !reset && load_addr_i == fetch_addr) ? load_data_i : mem[fetch_addr];
  assign next_byte = state == DATA ? fetch_data :
                     state == STAT ? STATUS_BYTE :
                     id_idx == 2'd1 ? JEDEC_ID[15:8] :
                     id_idx == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
  assign miso_o = miso_q && (state == DATA || state == STAT || state == ID);
  assign miso_oe_o = state != IDLE;
  assign busy_o = state != IDLE;
  always_ff @(posedge clk)
    if (!reset && load_en_i) mem[load_addr_i] <= load_data_i;
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s <= '0;
      cs_s <= '0;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk_i};
      cs_s <= {cs_s[1:0], cs_n_i};
      mosi_s <= {mosi_s[0], mosi_i};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rx <= '0;
      addr <= '0;
      tx <= '0;
      id_idx <= '0;
      miso_q <= 1'b0;
      last_cmd_o <= 8'h00;
      bad_cmd_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rx <= rx_n;
      addr <= addr_n;
      tx <= tx_n;
      id_idx <= id_idx_n;
      miso_q <= miso_n;
      last_cmd_o <= last_cmd_n;
      bad_cmd_o <= bad_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rx_n = rx;
    addr_n = addr;
    tx_n = tx;
    id_idx_n = id_idx;
    miso_n = miso_q;
    last_cmd_n = last_cmd_o;
    bad_n = 1'b0;
    if (state != IDLE && cs_hi) begin
      state_n = IDLE;
      cnt_n = '0;
      rx_n = '0;
      addr_n = '0;
      id_idx_n = '0;
      miso_n = 1'b0;
    end else begin
      case (state)
        IDLE: if (cs_fall) begin
          state_n = CMD;
          cnt_n = '0;
        end
        CMD: if (rise) begin
          rx_n = {rx[RW-2:0], bit_in};
          cnt_n = cnt + 5'd1;
          if (cnt == 5'd7) begin
            last_cmd_n = opcode;
            cnt_n = '0;
            miso_n = 1'b0;
            id_idx_n = 2'd1;
            tx_n = opcode == 8'h05 ? STATUS_BYTE : JEDEC_ID[23:16];
            state_n = opcode == 8'h03 ? ADDR : opcode == 8'h05 ? STAT : opcode == 8'h9F ? ID : IGNORE;
            bad_n = opcode != 8'h03 && opcode != 8'h05 && opcode != 8'h9F;
          end
        end
        ADDR: if (rise) begin
          rx_n = {rx[RW-2:0], bit_in};
          cnt_n = cnt + 5'd1;
          if (cnt == 5'd23) begin
            addr_n = fetch_addr;
            tx_n = fetch_data;
            cnt_n = '0;
            miso_n = 1'b0;
            state_n = DATA;
          end
        end
        DATA, STAT, ID: if (fall) begin
          miso_n = tx[7];
          tx_n = cnt[2:0] == 3'd7 ? next_byte : {tx[6:0], 1'b0};
          cnt_n = cnt[2:0] == 3'd7 ? 5'd0 : cnt + 5'd1;
          addr_n = state == DATA && cnt[2:0] == 3'd7 ? fetch_addr : addr;
          id_idx_n = state == ID && cnt[2:0] == 3'd7 && id_idx != 2'd3 ? id_idx + 2'd1 : id_idx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed and randomized SPI frames checked against a transaction-level flash model
module tb_spi_flash_responder;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
  localparam logic [23:0] JID = 24'hEF4016;
  localparam logic [7:0] STAT = 8'h00;
  logic clk = 0, reset = 1, sclk = 0, cs_n = 1, mosi = 0, load_en = 0;
  logic [AW-1:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic miso, miso_oe, busy, bad_cmd;
  logic [7:0] last_cmd;
  spi_flash_responder #(.MEM_DEPTH(DEPTH), .JEDEC_ID(JID), .STATUS_BYTE(STAT)) dut (
    .clk(clk), .reset(reset), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
    .miso_o(miso), .miso_oe_o(miso_oe), .load_en_i(load_en), .load_addr_i(load_addr),
    .load_data_i(load_data), .busy_o(busy), .last_cmd_o(last_cmd), .bad_cmd_o(bad_cmd)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  int bad_pulses = 0, bad_long = 0;
  logic bad_prev = 0;
  logic [7:0] model_mem [DEPTH];
  logic [7:0] model_last = 8'h00;
  logic [7:0] tx_buf [32];
  int abort_bits = -1, rst_bit = -1, ld_bit = -1;
  logic [AW-1:0] ld_addr;
  logic [7:0] ld_data;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bad_cmd && !bad_prev) bad_pulses++;
    if (bad_cmd && bad_prev) bad_long++;
    bad_prev = bad_cmd;
  end
  function automatic logic [7:0] expect_byte(input int j);
    logic [23:0] id;
    int a;
    id = JID;
    a = int'({tx_buf[1], tx_buf[2], tx_buf[3]});
    case (tx_buf[0])
      8'h03: return j < 4 ? 8'h00 : model_mem[(a + j - 4) % DEPTH];
      8'h05: return j < 1 ? 8'h00 : STAT;
      8'h9F: return (j == 0 || j > 3) ? 8'h00 : id[8*(3-j) +: 8];
      default: return 8'h00;
    endcase
  endfunction
  function automatic bit supported(input logic [7:0] op);
    return op == 8'h03 || op == 8'h05 || op == 8'h9F;
  endfunction
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic preload(input int a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1;
    load_addr = AW'(a);
    load_data = d;
    model_mem[a] = d;
    @(negedge clk);
    load_en = 0;
  endtask
  task automatic set_read(input logic [23:0] a);
    tx_buf[0] = 8'h03;
    tx_buf[1] = a[23:16];
    tx_buf[2] = a[15:8];
    tx_buf[3] = a[7:0];
  endtask
  task automatic spi_frame(input int nbytes, input int h);
    int bitno, bits_sent, bad0;
    logic [7:0] r;
    logic done, was_reset;
    bad0 = bad_pulses;
    done = 0;
    was_reset = 0;
    bits_sent = 0;
    @(negedge clk);
    cs_n = 0;
    wait_cyc(2);
    check("oe_before_sync", miso_oe, 0);
    wait_cyc(1);
    check("oe_after_sync", miso_oe, 1);
    check("busy_after_sync", busy, 1);
    wait_cyc(h > 4 ? h - 3 : 1);
    for (int j = 0; j < nbytes && !done; j++) begin
      r = 8'h00;
      for (int b = 7; b >= 0 && !done; b--) begin
        bitno = j * 8 + 7 - b;
        if (bitno == abort_bits) done = 1;
        else if (bitno == rst_bit) begin
          reset = 1;
          @(negedge clk);
          reset = 0;
          check("rst_miso", miso, 0);
          check("rst_oe", miso_oe, 0);
          check("rst_busy", busy, 0);
          check("rst_last", last_cmd, 0);
          check("rst_bad", bad_cmd, 0);
          model_last = 8'h00;
          for (int k = 0; k < 8; k++) begin
            mosi = k[0];
            wait_cyc(h);
            sclk = 1;
            wait_cyc(h);
            sclk = 0;
          end
          wait_cyc(4);
          check("no_resume_busy", busy, 0);
          check("no_resume_miso", miso, 0);
          done = 1;
          was_reset = 1;
        end else begin
          mosi = tx_buf[j][b];
          if (bitno == ld_bit) begin
            load_en = 1;
            load_addr = ld_addr;
            load_data = ld_data;
            model_mem[ld_addr] = ld_data;
            @(negedge clk);
            load_en = 0;
            wait_cyc(h - 1);
          end else wait_cyc(h);
          r[b] = miso;
          sclk = 1;
          wait_cyc(h);
          sclk = 0;
          bits_sent++;
        end
      end
      if (!done) check($sformatf("op%02h_byte%0d", tx_buf[0], j), r, expect_byte(j));
    end
    mosi = 0;
    wait_cyc(h);
    cs_n = 1;
    wait_cyc(2);
    check("busy_hold", busy, !was_reset);
    wait_cyc(1);
    check("busy_release", busy, 0);
    check("oe_release", miso_oe, 0);
    if (bits_sent >= 8 && !was_reset) model_last = tx_buf[0];
    check("last_cmd", last_cmd, model_last);
    check("bad_pulses", bad_pulses - bad0, (bits_sent >= 8 && !supported(tx_buf[0])) ? 1 : 0);
    wait_cyc(h);
    abort_bits = -1;
    rst_bit = -1;
    ld_bit = -1;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int sel, h, nb;
    wait_cyc(3);
    check("reset_miso", miso, 0);
    check("reset_oe", miso_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_last", last_cmd, 0);
    check("reset_bad", bad_cmd, 0);
    reset = 0;
    wait_cyc(4);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      load_en = 1;
      load_addr = AW'(i);
      load_data = 8'($urandom);
      model_mem[i] = load_data;
    end
    @(negedge clk);
    load_en = 0;
    for (int j = 0; j < 32; j++) tx_buf[j] = 8'h00;
    preload(0, 8'h11);
    preload(1, 8'h22);
    preload(2, 8'h33);
    preload(3, 8'h44);
    set_read(24'h000001);
    spi_frame(7, 4);
    tx_buf[0] = 8'h9F;
    spi_frame(6, 8);
    tx_buf[0] = 8'h05;
    spi_frame(4, 4);
    tx_buf[0] = 8'hAB;
    spi_frame(3, 4);
    set_read(24'h000000);
    spi_frame(5, 4);
    set_read(24'h000000);
    abort_bits = 21;
    spi_frame(5, 4);
    set_read(24'h000002);
    spi_frame(5, 8);
    set_read(24'h000000);
    rst_bit = 40;
    spi_frame(7, 4);
    set_read(24'h000001);
    spi_frame(5, 4);
    preload(4, 8'h96);
    preload(5, 8'h69);
    set_read(24'h000004);
    ld_bit = 35;
    ld_addr = 5;
    ld_data = 8'hC3;
    spi_frame(6, 8);
    preload(1023, 8'hA5);
    preload(0, 8'h5A);
    set_read(24'h0003FF);
    spi_frame(6, 4);
    set_read(24'h0403FF);
    spi_frame(6, 8);
    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 3);
      h = $urandom_range(0, 1) ? 8 : 4;
      for (int j = 0; j < 32; j++) tx_buf[j] = 8'($urandom);
      tx_buf[0] = sel == 0 ? 8'h03 : sel == 1 ? 8'h05 : sel == 2 ? 8'h9F : 8'($urandom);
      nb = tx_buf[0] == 8'h03 ? $urandom_range(1, 9) : $urandom_range(1, 6);
      spi_frame(nb, h);
    end
    check("bad_pulse_width", bad_long, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI mode-0 responder emulating the subset of a serial NOR flash that the SoC's flash boot path uses (READ 0x03, RDSR 0x05, RDID 0x9F). It sits on the far end of the SoC's flash SPI pins (`o_flash_sclk`, `o_flash_cs_n`, `o_flash_mosi`, `i_flash_miso`) in simulation and FPGA loopback builds. It serves bytes from an internal byte memory that the bench or a debug path preloads through a synchronous write port.

## Interface
- `MEM_DEPTH`, 1024: byte memory size; power of two, ≥ 16.
- `JEDEC_ID`, 24'hEF4016: 3-byte ID returned by RDID, MSB byte first.
- `STATUS_BYTE`, 8'h00: value returned by RDSR.

Ports:
- `clk` in 1: system clock; the only clock. SCLK is treated as data.
- `reset` in 1: synchronous, active-high reset.
- `sclk_i` in 1: SPI clock from the master; asynchronous to `clk`.
- `cs_n_i` in 1: chip select, active low; asynchronous.
- `mosi_i` in 1: master-out data; asynchronous.
- `miso_o` out 1: responder-out data.
- `miso_oe_o` out 1: high while `miso_o` is driven, i.e. CS asserted after sync.
- `load_en_i` in 1: byte write strobe into memory.
- `load_addr_i` in $clog2(MEM_DEPTH): write address.
- `load_data_i` in 8: write data.
- `busy_o` out 1: high whenever the state is not IDLE.
- `last_cmd_o` out 8: last complete opcode received; holds until the next opcode.
- `bad_cmd_o` out 1: one-cycle pulse when an unsupported opcode completes.

## Operation
- `sclk_i`, `cs_n_i`, `mosi_i` each pass through a 2-flop synchronizer. SCLK rise/fall pulses come from a third flop. Requirement: f_sclk ≤ f_clk/8.
- SPI mode 0, MSB first. MOSI is sampled on SCLK rise. MISO changes only on SCLK fall, or on CS assertion for the first bit.
- States: IDLE, CMD, ADDR, DATA, STAT, ID, IGNORE.
  - IDLE: waits for synced CS low, then goes to CMD with bit counter 0.
  - CMD: shifts 8 bits. On the 8th rise, `last_cmd_o` is updated.
    - 0x03 goes to ADDR (24 bits).
    - 0x05 goes to STAT.
    - 0x9F goes to ID.
    - Any other opcode goes to IGNORE and pulses `bad_cmd_o`.
  - ADDR: shifts 24 bits. On the 24th rise, the address register takes addr[23:0] mod MEM_DEPTH, the byte at that address is fetched into the TX shift register, and the state goes to DATA.
  - DATA: the MSB is driven on the next SCLK fall. Each later fall shifts out one bit. After the 8th bit's fall, the address increments and wraps MEM_DEPTH-1 → 0. The next byte is fetched and its MSB goes out on the following fall. This continues until CS rises.
  - STAT: `STATUS_BYTE` is shifted out repeatedly.
  - ID: the 3 ID bytes are shifted out, then 0x00 forever.
  - IGNORE: MOSI is ignored and `miso_o` = 0.
- In every state, CS deassert (synced) returns to IDLE in the same cycle. Partial bytes and the address are discarded; `last_cmd_o` is kept.
- `miso_o` = 0 whenever not in DATA/STAT/ID.
- Load port:
  - Writes take effect at the clock edge where `load_en_i` = 1, in any state.
  - If a write and a fetch hit the same address in the same cycle, the fetch returns the new data (write-first).
  - Loads are ignored during reset.
- Memory contents are not cleared by reset.

## Timing
- Reset values: `miso_o` 0, `miso_oe_o` 0, `busy_o` 0, `last_cmd_o` 8'h00, `bad_cmd_o` 0. State is IDLE and all counters are 0.
- Input-to-internal latency is 3 `clk` cycles (2 sync + edge detect).
- `miso_o` updates within 4 `clk` cycles of the pin-level SCLK fall. At the f_clk/8 limit this leaves ≥ 0 setup margin before the next rise. The bench runs at f_clk/8 and f_clk/16.
- `miso_oe_o` rises 3 cycles after CS falls and drops 3 cycles after CS rises.
- `bad_cmd_o` is asserted for exactly 1 cycle, 3 cycles after the 8th opcode rise.
- Reset asserted mid-transfer forces IDLE on that edge. A transfer already in progress is not resumed after reset releases; the responder waits for CS high, then low.

## Test plan
- Preload addr 0..3 = 0x11,0x22,0x33,0x44; READ 0x03 addr 0x000001, clock 24 data bits → MISO 0x22,0x33,0x44; `last_cmd_o`=0x03.
- MEM_DEPTH=1024, preload 0x3FF=0xA5, 0x000=0x5A; READ addr 0x0003FF (and separately 0x0403FF, upper bits ignored), 2 bytes → 0xA5,0x5A (wrap).
- RDID, 5 bytes → 0xEF,0x40,0x16,0x00,0x00; RDSR 3 bytes → 0x00 ×3; `bad_cmd_o` never pulses.
- Opcode 0xAB → `bad_cmd_o` one-cycle pulse, MISO 0 for 16 following bits; next CS cycle READ addr 0 returns 0x11.
- CS raised after 13 address bits, then READ addr 2 → 0x33 (abort clean, `busy_o` low within 3 cycles); `reset` pulsed mid-DATA → all outputs at reset values, next READ correct.
- During READ streaming from addr 4, write 0xC3 to addr 5 before byte at 5 is fetched → second byte = 0xC3.
